// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan scheduler for an 8-digit seven-segment display.
// Optional feature macro SEG_SCROLL_EN rotates the shown digits left every SCROLL_DIV frames.
module seg_scan_ctrl #(
    parameter int CLK_DIV    = 50000,
    parameter int SCROLL_DIV = 200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [2:0] wr_addr,
    input  logic [3:0] wr_data,
    output logic [7:0] led,
    output logic [2:0] del,
    output logic       frame_done
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [2:0]       del_next;
    logic [2:0]       offset;
    logic [2:0]       rd_idx;
    logic [3:0]       digit_buf [8];

    // Active-high segments, bit order dp,g,f,e,d,c,b,a with dp held low.
    function automatic logic [7:0] seg_decode(input logic [3:0] h);
        logic [7:0] s;
        case (h)
            4'h0:    s = 8'h3F;
            4'h1:    s = 8'h06;
            4'h2:    s = 8'h5B;
            4'h3:    s = 8'h4F;
            4'h4:    s = 8'h66;
            4'h5:    s = 8'h6D;
            4'h6:    s = 8'h7D;
            4'h7:    s = 8'h07;
            4'h8:    s = 8'h7F;
            4'h9:    s = 8'h6F;
            4'hA:    s = 8'h77;
            4'hB:    s = 8'h7C;
            4'hC:    s = 8'h39;
            4'hD:    s = 8'h5E;
            4'hE:    s = 8'h79;
            default: s = 8'h71;
        endcase
        return s;
    endfunction

    assign tick     = (div_cnt == DIV_W'(CLK_DIV - 1));
    // Blocking writes on tick keeps the buffer read and write in separate cycles.
    assign wr_ready = ~tick;
    assign del_next = del + 3'd1;
    assign rd_idx   = del_next + offset;

    // Prescaler stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Digit buffer write stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                digit_buf[i] <= 4'h0;
            end
        end else if (wr_valid && wr_ready) begin
            digit_buf[wr_addr] <= wr_data;
        end
    end

    // Scan output stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            del        <= 3'd0;
            led        <= 8'h00;
            frame_done <= 1'b0;
        end else begin
            frame_done <= tick && (del == 3'd7);
            if (tick) begin
                del <= del_next;
                led <= en ? seg_decode(digit_buf[rd_idx]) : 8'h00;
            end
        end
    end

`ifdef SEG_SCROLL_EN
    localparam int FR_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

    logic [FR_W-1:0] frame_cnt;

    // Scroll stage: offset advances once per SCROLL_DIV completed frames
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            offset    <= 3'd0;
        end else if (frame_done) begin
            if (frame_cnt == FR_W'(SCROLL_DIV - 1)) begin
                frame_cnt <= '0;
                offset    <= offset + 3'd1;
            end else begin
                frame_cnt <= frame_cnt + FR_W'(1);
            end
        end
    end
`else
    logic unused_scroll_cfg;

    assign offset            = 3'd0;
    assign unused_scroll_cfg = (SCROLL_DIV < 1);
`endif

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: cycle-level behavioural model plus literal spot checks.
`timescale 1ns/1ps
module tb_seg_scan_ctrl;

    localparam int CLK_DIV    = 4;
    localparam int SCROLL_DIV = 1;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b1;
    logic       en       = 1'b0;
    logic       wr_valid = 1'b0;
    logic [2:0] wr_addr  = 3'd0;
    logic [3:0] wr_data  = 4'h0;
    logic       wr_ready;
    logic [7:0] led;
    logic [2:0] del;
    logic       frame_done;

    seg_scan_ctrl #(.CLK_DIV(CLK_DIV), .SCROLL_DIV(SCROLL_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .led(led), .del(del), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    logic [7:0] seg_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                 8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    // Reference state: e = clock edges since reset release; scan position follows from e.
    int         e;
    logic [3:0] mbuf [8];
    logic [7:0] mled;
    logic [2:0] mdel;
    logic       mfd;
    int         nfr;
    int         moff;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(posedge clk or negedge rst_n) begin : model
        bit tk;
        int d;
        int nf;
        if (!rst_n) begin
            e    <= 0;
            for (int i = 0; i < 8; i++) mbuf[i] <= 4'h0;
            mled <= 8'h00;
            mdel <= 3'd0;
            mfd  <= 1'b0;
            nfr  <= 0;
            moff <= 0;
        end else begin
            tk = ((e % CLK_DIV) == CLK_DIV - 1);
            nf = nfr + (mfd ? 1 : 0);
            nfr <= nf;
`ifdef SEG_SCROLL_EN
            moff <= (nf / SCROLL_DIV) % 8;
`endif
            if (tk) begin
                d = ((e + 1) / CLK_DIV) % 8;
                mdel <= 3'(d);
                mled <= en ? seg_tab[mbuf[(d + moff) % 8]] : 8'h00;
                mfd  <= (d == 0);
            end else begin
                mfd <= 1'b0;
            end
            if (wr_valid && !tk) mbuf[wr_addr] <= wr_data;
            e <= e + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("led", led, mled);
            check("del", del, mdel);
            check("frame_done", frame_done, mfd);
            check("wr_ready", wr_ready, (e % CLK_DIV) != CLK_DIV - 1);
        end
    end

    task automatic wait_scan(input logic [2:0] d);
        int n = 0;
        while (del == d && n < 300) begin @(negedge clk); n++; end
        while (del != d && n < 300) begin @(negedge clk); n++; end
        check("scan_reach", del, d);
    endtask

    task automatic do_write(input logic [2:0] a, input logic [3:0] dv);
        int n = 0;
        while (!wr_ready && n < 8) begin @(negedge clk); n++; end
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = dv;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int lowcnt;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_led", led, 8'h00);
        check("rst_del", del, 3'd0);
        check("rst_wr_ready", wr_ready, 1'b1);
        rst_n = 1'b1;
        en    = 1'b1;

        for (int i = 0; i < 8; i++) do_write(3'(i), 4'(i));
`ifdef SEG_SCROLL_EN
        wait_scan(3'd0);
        check("scroll_f1_d0", led, 8'h3F);
        wait_scan(3'd0);
        check("scroll_f2_d0", led, 8'h06);
        repeat (7) wait_scan(3'd0);
        check("scroll_wrap_d0", led, 8'h3F);
`else
        wait_scan(3'd0);
        check("scan_d0", led, 8'h3F);
        wait_scan(3'd1);
        check("scan_d1", led, 8'h06);
        wait_scan(3'd7);
        check("scan_d7", led, 8'h07);
`endif

        cnt = 0;
        while (!frame_done && cnt < 100) begin @(negedge clk); cnt++; end
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (!frame_done && cnt < 100);
        check("fd_period", cnt, 32);

        wr_valid = 1'b1;
        wr_addr  = 3'd5;
        lowcnt   = 0;
        for (int i = 0; i < 40; i++) begin
            wr_data = 4'($urandom);
            @(negedge clk);
            if (!wr_ready) lowcnt++;
        end
        wr_valid = 1'b0;
        check("ready_low_count", lowcnt, 10);

        do_write(3'd3, 4'h8);
        wait_scan(3'd3);
`ifndef SEG_SCROLL_EN
        check("write_d3", led, 8'h7F);
`endif

        wait_scan(3'd0);
        en = 1'b0;
        wait_scan(3'd1);
        check("blank_led", led, 8'h00);
        repeat (31) begin
            @(negedge clk);
            check("blank_hold", led, 8'h00);
        end
        en = 1'b1;
        wait_scan(3'(del + 3'd1));
        check("unblank_led", led != 8'h00, 1'b1);

        for (int i = 0; i < 800; i++) begin
            wr_valid = 1'($urandom_range(0, 1));
            wr_addr  = 3'($urandom);
            wr_data  = 4'($urandom);
            if ($urandom_range(0, 31) == 0) en = ~en;
            @(negedge clk);
        end
        wr_valid = 1'b0;
        en       = 1'b1;

`ifdef SEG_SCROLL_EN
        cnt = 0;
        while (moff != 5 && cnt < 400) begin @(negedge clk); cnt++; end
`endif
        wr_valid = 1'b1;
        wr_addr  = 3'd2;
        wr_data  = 4'hF;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_led", led, 8'h00);
        check("midrst_del", del, 3'd0);
        check("midrst_fd", frame_done, 1'b0);
        check("midrst_wr_ready", wr_ready, 1'b1);
        repeat (2) @(negedge clk);
        wr_valid = 1'b0;
        rst_n    = 1'b1;
        wait_scan(3'd1);
        check("post_rst_cleared", led, 8'h3F);
        repeat (40) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
